opll_bus_writer: RTL and testbench

Host-side register-write sequencer placed directly upstream of the OPLL core in the Tiny Tapeout top. It accepts register address/data pairs over a valid/ready handshake and buffers them in a small FIFO. It replays each pair onto the OPLL CPU bus (CS_n/WR_n/A0/D) and enforces the YM2413 write-recovery times: 12 master cycles after an address write, 84 after a data write. The host therefore never needs to count master cycles itself.

---
 rtl/opll_bus_pkg.sv | 21 ++
 rtl/opll_wr_fifo.sv | 79 +++++++
 rtl/opll_bus_writer.sv | 171 +++++++++++++++++
 tb/tb_opll_bus_writer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opll_bus_pkg.sv
// Shared types and default write-recovery constants for the OPLL host write path.
package opll_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_STB = 3'd1,
    ST_ADDR_REC = 3'd2,
    ST_DATA_STB = 3'd3,
    ST_DATA_REC = 3'd4
  } opll_state_t;

  // YM2413 recovery times in master-clock ticks.
  localparam int OPLL_ADDR_WAIT = 12;
  localparam int OPLL_DATA_WAIT = 84;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } opll_pair_t;

endpackage

// File: rtl/opll_wr_fifo.sv
// Small synchronous FIFO of {addr,data} pairs; head is read straight from storage
// (first-word-fall-through) and the count/flags are registered.
module opll_wr_fifo
  import opll_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  opll_pair_t               push_pair,
  input  logic                     pop,
  output opll_pair_t               head_pair,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  opll_pair_t          mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic                full_r;
  logic                empty_r;
  logic                push_fire_s;
  logic                pop_fire_s;
  logic [CW-1:0]       count_next_s;

  // Qualified handshakes and next occupancy.
  always_comb begin
    push_fire_s  = push && !full_r;
    pop_fire_s   = pop && !empty_r;
    count_next_s = count_r;
    if (push_fire_s && !pop_fire_s) begin
      count_next_s = count_r + CW'(1);
    end else if (pop_fire_s && !push_fire_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_fire_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_fire_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == {CW{1'b0}});
    end
  end

  // Pair storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_fire_s) begin
      mem_r[wr_ptr_r] <= push_pair;
    end
  end

  assign head_pair = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;

endmodule

// File: rtl/opll_bus_writer.sv
// Replays buffered register writes onto the OPLL CPU bus, pacing strobes and
// YM2413 write-recovery gaps in phi_cen ticks.
module opll_bus_writer
  import opll_bus_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STROBE_TICKS = 2,
  parameter int ADDR_WAIT    = OPLL_ADDR_WAIT,
  parameter int DATA_WAIT    = OPLL_DATA_WAIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          phi_cen,
  input  logic                          in_valid,
  input  logic [7:0]                    in_addr,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          opll_cs_n,
  output logic                          opll_wr_n,
  output logic                          opll_a0,
  output logic [7:0]                    opll_d,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW  = $clog2(DATA_WAIT);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  opll_state_t     state_r;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      data_r;
  logic            cs_n_r;
  logic            wr_n_r;
  logic            a0_r;
  logic [7:0]      d_r;
  logic            busy_r;

  opll_pair_t      in_pair_s;
  opll_pair_t      head_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [FCW-1:0]  fifo_count_s;
  logic            push_s;
  logic            pop_s;
  logic            cnt_zero_s;
  logic            done_s;
  logic            idle_next_s;
  logic            nonempty_next_s;

  assign in_pair_s = '{addr: in_addr, data: in_data};

  opll_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_pair (in_pair_s),
    .pop       (pop_s),
    .head_pair (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Handshake decode and the look-ahead used to register busy.
  always_comb begin
    push_s      = in_valid && !fifo_full_s;
    pop_s       = (state_r == ST_IDLE) && phi_cen && !fifo_empty_s;
    cnt_zero_s  = (cnt_r == {CW{1'b0}});
    done_s      = (state_r == ST_DATA_REC) && phi_cen && cnt_zero_s;
    idle_next_s = ((state_r == ST_IDLE) && !pop_s) || done_s;
    if (push_s) begin
      nonempty_next_s = 1'b1;
    end else if (pop_s) begin
      nonempty_next_s = (fifo_count_s > FCW'(1));
    end else begin
      nonempty_next_s = !fifo_empty_s;
    end
  end

  // Busy reflects the state and occupancy that will hold after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= !idle_next_s || nonempty_next_s;
    end
  end

  // Bus sequencer: everything advances only on phi_cen ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      data_r  <= 8'h00;
      cs_n_r  <= 1'b1;
      wr_n_r  <= 1'b1;
      a0_r    <= 1'b0;
      d_r     <= 8'h00;
    end else if (phi_cen) begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            data_r  <= head_s.data;
            d_r     <= head_s.addr;
            a0_r    <= 1'b0;
            cs_n_r  <= 1'b0;
            wr_n_r  <= 1'b0;
            cnt_r   <= CW'(STROBE_TICKS - 1);
            state_r <= ST_ADDR_STB;
          end
        end
        ST_ADDR_STB: begin
          if (cnt_zero_s) begin
            cs_n_r  <= 1'b1;
            wr_n_r  <= 1'b1;
            cnt_r   <= CW'(ADDR_WAIT - 1);
            state_r <= ST_ADDR_REC;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_ADDR_REC: begin
          if (cnt_zero_s) begin
            d_r     <= data_r;
            a0_r    <= 1'b1;
            cs_n_r  <= 1'b0;
            wr_n_r  <= 1'b0;
            cnt_r   <= CW'(STROBE_TICKS - 1);
            state_r <= ST_DATA_STB;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_DATA_STB: begin
          if (cnt_zero_s) begin
            cs_n_r  <= 1'b1;
            wr_n_r  <= 1'b1;
            cnt_r   <= CW'(DATA_WAIT - 1);
            state_r <= ST_DATA_REC;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_DATA_REC: begin
          // Returning to IDLE here keeps the next pop off the terminal tick.
          if (cnt_zero_s) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          cs_n_r  <= 1'b1;
          wr_n_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = !fifo_full_s;
  assign opll_cs_n  = cs_n_r;
  assign opll_wr_n  = wr_n_r;
  assign opll_a0    = a0_r;
  assign opll_d     = d_r;
  assign busy       = busy_r;
  assign fifo_count = fifo_count_s;

endmodule

// File: tb/tb_opll_bus_writer.sv
// Directed bench for opll_bus_writer: cycle-segment vector table, hand-written
// corner sequences and a bus-monitor scoreboard.
module tb_opll_bus_writer;

  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_addr = 8'h00;
  logic [7:0] in_data = 8'h00;
  logic       phi_force = 1'b1;
  logic [1:0] phi_src = 2'd0;
  logic [1:0] div_cnt = 2'd0;
  logic       rnd_ph = 1'b0;
  logic       phi_cen;

  logic       in_ready, opll_cs_n, opll_wr_n, opll_a0, busy;
  logic [7:0] opll_d;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  opll_bus_writer dut (
    .clk        (clk),
    .rst        (rst),
    .phi_cen    (phi_cen),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .opll_cs_n  (opll_cs_n),
    .opll_wr_n  (opll_wr_n),
    .opll_a0    (opll_a0),
    .opll_d     (opll_d),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // phi_cen source: constant, 1-in-4, or random.
  always @(posedge clk) begin
    div_cnt <= div_cnt + 2'd1;
    rnd_ph  <= 1'($urandom_range(0, 1));
  end
  assign phi_cen = (phi_src == 2'd1) ? (div_cnt == 2'd3) :
                   (phi_src == 2'd2) ? rnd_ph : phi_force;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_ge(input string name, input int act, input int lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("FAIL %s got %0d required >= %0d", name, act, lim);
    end
  endfunction

  // Scoreboard feed: every accepted pair is expected on the bus once.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) sb.push_back({in_addr, in_data});
  end

  // Bus monitor, stamps events in phi_cen ticks.
  logic       prev_wr = 1'b1;
  int         ticks = 0, fall_tick = 0, arise_tick = 0, drise_tick = 0, strobes = 0;
  bit         have_fall = 0, have_arise = 0, have_drise = 0;
  logic [7:0] mon_addr = 8'h00;
  logic [15:0] exp_pair;

  always @(negedge clk) begin
    if (rst) begin
      prev_wr    = 1'b1;
      have_fall  = 0;
      have_arise = 0;
      have_drise = 0;
    end else begin
      if (prev_wr === 1'b1 && opll_wr_n === 1'b0) begin
        strobes++;
        fall_tick = ticks;
        have_fall = 1;
        chk("mon_cs_n_low", opll_cs_n, 0);
        if (opll_a0 === 1'b0) begin
          if (have_drise) chk_ge("mon_data_recovery", ticks - drise_tick, DATA_WAIT + 1);
          mon_addr = opll_d;
        end else begin
          if (have_arise) chk("mon_addr_recovery", ticks - arise_tick, ADDR_WAIT);
          chk_ge("mon_pair_expected", sb.size(), 1);
          if (sb.size() > 0) begin
            exp_pair = sb.pop_front();
            chk("mon_pair", {mon_addr, opll_d}, exp_pair);
          end
        end
      end
      if (prev_wr === 1'b0 && opll_wr_n === 1'b1 && have_fall) begin
        chk("mon_strobe_width", ticks - fall_tick, 2);
        if (opll_a0 === 1'b0) begin
          arise_tick = ticks;
          have_arise = 1;
        end else begin
          drise_tick = ticks;
          have_drise = 1;
        end
      end
      prev_wr = opll_wr_n;
    end
    ticks += (phi_cen === 1'b1) ? 1 : 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    for (int n = 0; n < 2000; n++) begin
      if (in_ready === 1'b1) begin
        ok = 1;
        step();
        break;
      end
      step();
    end
    if (!ok) chk("push_accept", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_wr(input logic lvl, output int n);
    n = 0;
    while (opll_wr_n !== lvl && n < 2000) begin
      step();
      n++;
    end
    chk("wait_wr", opll_wr_n, lvl);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      step();
      n++;
    end
    chk(name, busy, 0);
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] addr;
    logic [7:0] data;
    int         cycles;
    logic       wr_n;
    logic       a0;
    logic [7:0] d;
    logic       busy;
    logic [2:0] cnt;
    logic       rdy;
  } vec_t;

  vec_t vecs[12];
  int   n;
  int   s0;

  initial begin
    // Segments: inputs held for 'cycles' clocks, outputs checked after every edge.
    vecs[0]  = '{1'b1, 8'h10, 8'h55, 1,  1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 2,  1'b0, 1'b0, 8'h10, 1'b1, 3'd0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 12, 1'b1, 1'b0, 8'h10, 1'b1, 3'd0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 2,  1'b0, 1'b1, 8'h55, 1'b1, 3'd0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 84, 1'b1, 1'b1, 8'h55, 1'b1, 3'd0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1,  1'b1, 1'b1, 8'h55, 1'b0, 3'd0, 1'b1};
    vecs[6]  = '{1'b1, 8'hA3, 8'h0F, 1,  1'b1, 1'b1, 8'h55, 1'b1, 3'd1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 2,  1'b0, 1'b0, 8'hA3, 1'b1, 3'd0, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 12, 1'b1, 1'b0, 8'hA3, 1'b1, 3'd0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 2,  1'b0, 1'b1, 8'h0F, 1'b1, 3'd0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 84, 1'b1, 1'b1, 8'h0F, 1'b1, 3'd0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1,  1'b1, 1'b1, 8'h0F, 1'b0, 3'd0, 1'b1};

    repeat (2) step();
    chk("rst_wr_n", opll_wr_n, 1);
    chk("rst_cs_n", opll_cs_n, 1);
    chk("rst_a0", opll_a0, 0);
    chk("rst_d", opll_d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;

    // Single writes, phi_cen held high.
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].valid;
      in_addr  = vecs[i].addr;
      in_data  = vecs[i].data;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step();
        chk($sformatf("vec%0d_c%0d_wr_n", i, c), opll_wr_n, vecs[i].wr_n);
        chk($sformatf("vec%0d_c%0d_cs_n", i, c), opll_cs_n, vecs[i].wr_n);
        chk($sformatf("vec%0d_c%0d_a0", i, c), opll_a0, vecs[i].a0);
        chk($sformatf("vec%0d_c%0d_d", i, c), opll_d, vecs[i].d);
        chk($sformatf("vec%0d_c%0d_busy", i, c), busy, vecs[i].busy);
        chk($sformatf("vec%0d_c%0d_count", i, c), fifo_count, vecs[i].cnt);
        chk($sformatf("vec%0d_c%0d_ready", i, c), in_ready, vecs[i].rdy);
      end
    end
    in_valid = 1'b0;

    // Back-pressure: fill with phi_cen stalled, then release.
    do_reset();
    phi_force = 1'b0;
    push(8'h01, 8'h11);
    push(8'h02, 8'h22);
    push(8'h03, 8'h33);
    push(8'h04, 8'h44);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_count_full", fifo_count, 4);
    chk("bp_busy_queued", busy, 1);
    in_valid = 1'b1;
    in_addr  = 8'h05;
    in_data  = 8'h55;
    step();
    chk("bp_blocked_count", fifo_count, 4);
    phi_force = 1'b1;
    step();
    chk("bp_pop_count", fifo_count, 3);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_refill_count", fifo_count, 4);
    chk("bp_refill_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_idle("bp_idle", 3000);
    chk("bp_all_replayed", sb.size(), 0);

    // Simultaneous push and pop with two entries held.
    do_reset();
    phi_force = 1'b0;
    push(8'h30, 8'hC0);
    push(8'h31, 8'hC1);
    chk("pp_count_before", fifo_count, 2);
    in_valid  = 1'b1;
    in_addr   = 8'h32;
    in_data   = 8'hC2;
    phi_force = 1'b1;
    step();
    chk("pp_count_same", fifo_count, 2);
    in_valid = 1'b0;
    wait_idle("pp_idle", 2000);
    chk("pp_all_replayed", sb.size(), 0);

    // phi_cen at 1-in-4.
    do_reset();
    phi_src = 2'd1;
    push(8'h20, 8'h7E);
    wait_wr(1'b0, n);
    wait_wr(1'b1, n);
    chk("div4_addr_strobe_clks", n, 8);
    wait_wr(1'b0, n);
    chk("div4_addr_to_data_clks", n, 48);
    wait_wr(1'b1, n);
    chk("div4_data_strobe_clks", n, 8);
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      step();
      n++;
    end
    chk("div4_data_recovery_clks", n, 336);
    phi_src = 2'd0;
    phi_force = 1'b1;

    // Reset during the data strobe of the first of three pairs.
    do_reset();
    push(8'h40, 8'hA0);
    push(8'h41, 8'hA1);
    push(8'h42, 8'hA2);
    n = 0;
    while (!(opll_a0 === 1'b1 && opll_wr_n === 1'b0) && n < 200) begin
      step();
      n++;
    end
    chk("rs_in_data_stb", {opll_a0, opll_wr_n}, 2'b10);
    chk("rs_queued", fifo_count, 2);
    rst = 1'b1;
    step();
    chk("rs_cs_n", opll_cs_n, 1);
    chk("rs_wr_n", opll_wr_n, 1);
    chk("rs_a0", opll_a0, 0);
    chk("rs_d", opll_d, 0);
    chk("rs_count", fifo_count, 0);
    chk("rs_busy", busy, 0);
    rst = 1'b0;
    sb.delete();
    s0 = strobes;
    repeat (300) step();
    chk("rs_no_strobes", strobes - s0, 0);
    chk("rs_still_idle", busy, 0);

    // Random pairs with random phi_cen, checked by the monitor.
    do_reset();
    phi_src = 2'd2;
    for (int i = 0; i < 6; i++) begin
      push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    wait_idle("rnd_idle", 6000);
    phi_src = 2'd0;
    step();

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
